// File: rtl/img_cap_pkg.sv
// Shared definitions for the image capture path: signal polarities, memory
// geometry, frame size and the frame reader FSM encoding.
package img_cap_pkg;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

  localparam int MEM_ADDR_W   = 24;
  localparam int MEM_DATA_W   = 32;
  localparam int PIX_W        = 24;

  localparam int FRAME_COLS   = 640;
  localparam int FRAME_ROWS   = 480;
  localparam int FRAME_PIXELS = FRAME_COLS * FRAME_ROWS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/frame_rd_fifo.sv
// Synchronous return-data FIFO with registered occupancy; the head word is
// visible the cycle after it is written (no fall-through).
module frame_rd_fifo
  import img_cap_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = PIX_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             rd_clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  // Gating keeps the head at zero while empty, so unwritten storage never leaks out.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
  end

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge rd_clk or negedge reset) begin
    if (reset == ASSERT_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; only the pointers define what is valid.
  always_ff @(posedge rd_clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/frame_rd_stream.sv
// Frame read streamer: issues credit-limited word reads for one frame and
// streams the returned pixels out with sof/eof markers.
module frame_rd_stream
  import img_cap_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = MEM_ADDR_W,
  parameter int                    DATA_WIDTH  = MEM_DATA_W,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    FRAME_WORDS = FRAME_PIXELS,
  parameter int                    FIFO_DEPTH  = 8
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rd_rdy,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_data_valid,
  output logic [PIX_W-1:0]      pix_data,
  output logic                  pix_valid,
  input  logic                  pix_rdy,
  output logic                  sof,
  output logic                  eof,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  localparam int OUT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int CR_W  = OUT_W + 1;

  rd_state_e        state_q, state_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] accept_cnt_q, accept_cnt_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [FC_W-1:0]  fifo_count;
  logic             fifo_empty;
  logic             unused_fifo_full;
  logic             unused_rd_data_hi;
  logic             rv_legal;
  logic             pix_accept;
  logic [CR_W-1:0]  credit_used;

  assign unused_rd_data_hi = ^rd_data[DATA_WIDTH-1:PIX_W];

  // Returns with nothing in flight are dropped before reaching the FIFO.
  assign rv_legal    = rd_data_valid && (outstanding_q != '0);
  assign pix_valid   = !fifo_empty;
  assign pix_accept  = pix_valid && pix_rdy;
  assign credit_used = CR_W'(outstanding_q) + CR_W'(fifo_count);

  assign rd_en   = (state_q == ST_ISSUE) && rd_rdy && (credit_used < CR_W'(FIFO_DEPTH));
  assign rd_addr = BASE_ADDR + ADDR_WIDTH'(issue_cnt_q);

  assign sof  = pix_valid && (accept_cnt_q == '0);
  assign eof  = pix_valid && (accept_cnt_q == CNT_W'(FRAME_WORDS - 1));
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign err  = err_q;

  frame_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .rd_clk  (rd_clk),
    .reset   (reset),
    .wr_en   (rv_legal),
    .wr_data (rd_data[PIX_W-1:0]),
    .rd_en   (pix_accept),
    .rd_data (pix_data),
    .empty   (fifo_empty),
    .full    (unused_fifo_full),
    .count   (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q + CNT_W'(rd_en);
    accept_cnt_d = accept_cnt_q + CNT_W'(pix_accept);
    done_d       = DEASSERT_H;
    err_d        = err_q | (rd_data_valid && (outstanding_q == '0));

    unique case ({rd_en, rv_legal})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_ISSUE;
          issue_cnt_d  = '0;
          accept_cnt_d = '0;
        end
      end
      ST_ISSUE: begin
        if (issue_cnt_d == CNT_W'(FRAME_WORDS)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (accept_cnt_d == CNT_W'(FRAME_WORDS)) begin
          state_d = ST_IDLE;
          done_d  = ASSERT_H;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge reset) begin
    if (reset == ASSERT_L) begin
      state_q       <= ST_IDLE;
      issue_cnt_q   <= '0;
      accept_cnt_q  <= '0;
      outstanding_q <= '0;
      done_q        <= DEASSERT_H;
      err_q         <= DEASSERT_H;
    end else begin
      state_q       <= state_d;
      issue_cnt_q   <= issue_cnt_d;
      accept_cnt_q  <= accept_cnt_d;
      outstanding_q <= outstanding_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_frame_rd_stream.sv
// Self-checking bench for frame_rd_stream: memory model with in-order returns,
// pixel scoreboard, table of frame scenarios plus stall/error/reset sequences.
module tb_frame_rd_stream;

  localparam int          FW   = 16;
  localparam int          FD   = 8;
  localparam logic [23:0] BASE = 24'h100;

  logic        rd_clk = 1'b0;
  logic        reset, start, rd_rdy, rd_en, rd_data_valid, pix_rdy;
  logic [23:0] rd_addr, pix_data;
  logic [31:0] rd_data;
  logic        pix_valid, sof, eof, busy, done, err;

  always #5 rd_clk = ~rd_clk;

  frame_rd_stream #(
    .ADDR_WIDTH  (24),
    .DATA_WIDTH  (32),
    .BASE_ADDR   (BASE),
    .FRAME_WORDS (FW),
    .FIFO_DEPTH  (FD)
  ) dut (
    .rd_clk        (rd_clk),
    .reset         (reset),
    .start         (start),
    .rd_rdy        (rd_rdy),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .pix_rdy       (pix_rdy),
    .sof           (sof),
    .eof           (eof),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  typedef struct {
    logic [23:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    string name;
    int    rdy_mode;    // 0 always ready, 1 toggling, 2 random
    int    lat_lo;
    int    lat_hi;
    int    prdy_mode;   // 0 always ready, 1 never, 2 random
    int    restart_at;  // cycle offset of a second start pulse, -1 none
    int    exp_words;
    int    exp_dones;
  } scn_t;

  pend_t       pend_q[$];
  logic [23:0] exp_q[$];
  int checks = 0, failures = 0;
  int cyc = 0, issued, accepted, done_cnt, last_due, last_acc_cyc, done_cyc;
  int rdy_mode = 0, prdy_mode = 0, lat_lo = 3, lat_hi = 3;
  bit start_req = 1'b0, spurious_req = 1'b0;

  function automatic logic [23:0] pix_of(input logic [23:0] a);
    return (a * 24'd40503) ^ 24'h5A5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flush();
    pend_q.delete();
    exp_q.delete();
    issued = 0; accepted = 0; done_cnt = 0;
    last_due = 0; last_acc_cyc = -1; done_cyc = -1;
  endtask

  // One clock: drive inputs just after the rising edge, observe at the falling edge.
  task automatic step();
    pend_t p;
    int    lat, due;
    logic [23:0] e;
    @(posedge rd_clk);
    #1;
    cyc++;
    case (rdy_mode)
      0:       rd_rdy = 1'b1;
      1:       rd_rdy = cyc[0];
      default: rd_rdy = 1'($urandom_range(0, 1));
    endcase
    case (prdy_mode)
      0:       pix_rdy = 1'b1;
      1:       pix_rdy = 1'b0;
      default: pix_rdy = 1'($urandom_range(0, 1));
    endcase
    start     = start_req;
    start_req = 1'b0;
    if (spurious_req) begin
      rd_data_valid = 1'b1;
      rd_data       = 32'hDEAD_BEEF;
      spurious_req  = 1'b0;
    end else if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      p             = pend_q.pop_front();
      rd_data_valid = 1'b1;
      rd_data       = {8'hA5 ^ p.addr[7:0], pix_of(p.addr)};
    end else begin
      rd_data_valid = 1'b0;
      rd_data       = $urandom();
    end

    @(negedge rd_clk);
    if (rd_en) begin
      check("rd_en_while_rdy", 32'(rd_rdy), 32'd1);
      check("rd_addr", 32'(rd_addr), 32'(BASE + 24'(issued)));
      lat = $urandom_range(lat_lo, lat_hi);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_q.push_back('{addr: rd_addr, due: due});
      exp_q.push_back(pix_of(BASE + 24'(issued)));
      issued++;
    end
    if (pix_valid && pix_rdy) begin
      if (exp_q.size() == 0) begin
        check("pix_unexpected_valid", 32'(pix_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pix_data", 32'(pix_data), 32'(e));
        check("sof", 32'(sof), 32'(accepted == 0));
        check("eof", 32'(eof), 32'(accepted == FW - 1));
        accepted++;
        last_acc_cyc = cyc;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic begin_frame();
    flush();
    start_req = 1'b1;
    step();
    check("busy_in_start_cycle", 32'(busy), 32'd0);
    step();
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic run_until_done(input int budget, input int restart_at);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      if (n == restart_at) start_req = 1'b1;
      step();
      n++;
    end
    if (done_cnt == 0) check("done_timeout", 32'(done_cnt), 32'd1);
    repeat (6) step();
  endtask

  task automatic end_frame_checks(input string tag, input int exp_words, input int exp_dones);
    check({tag, "_issued"},   32'(issued),   32'(exp_words));
    check({tag, "_accepted"}, 32'(accepted), 32'(exp_words));
    check({tag, "_dones"},    32'(done_cnt), 32'(exp_dones));
    check({tag, "_done_lat"}, 32'(done_cyc), 32'(last_acc_cyc + 1));
    check({tag, "_busy_end"}, 32'(busy),     32'd0);
    check({tag, "_sb_empty"}, 32'(exp_q.size() + pend_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_en"},     32'(rd_en),     32'd0);
    check({tag, "_rd_addr"},   32'(rd_addr),   32'(BASE));
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix_data"},  32'(pix_data),  32'd0);
    check({tag, "_sof"},       32'(sof),       32'd0);
    check({tag, "_eof"},       32'(eof),       32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_err"},       32'(err),       32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $finish;
  end

  initial begin
    scn_t tbl[4];
    int   n;
    tbl[0] = '{"basic",   0, 3, 3,  0, -1, FW, 1};
    tbl[1] = '{"toggle",  1, 2, 10, 0, -1, FW, 1};
    tbl[2] = '{"random",  2, 2, 10, 2, -1, FW, 1};
    tbl[3] = '{"restart", 0, 3, 3,  0,  6, FW, 1};

    reset = 1'b0; start = 1'b0; rd_rdy = 1'b0; pix_rdy = 1'b0;
    rd_data_valid = 1'b0; rd_data = '0;
    flush();
    repeat (3) @(negedge rd_clk);
    check_reset_values("por");
    reset = 1'b1;

    foreach (tbl[i]) begin
      rdy_mode  = tbl[i].rdy_mode;
      lat_lo    = tbl[i].lat_lo;
      lat_hi    = tbl[i].lat_hi;
      prdy_mode = tbl[i].prdy_mode;
      begin_frame();
      run_until_done(3000, tbl[i].restart_at);
      end_frame_checks(tbl[i].name, tbl[i].exp_words, tbl[i].exp_dones);
      check({tbl[i].name, "_err"}, 32'(err), 32'd0);
    end

    // Consumer stalled: credit limit must stop issue at FIFO depth.
    rdy_mode = 0; lat_lo = 3; lat_hi = 3; prdy_mode = 1;
    begin_frame();
    repeat (40) step();
    check("stall_issued",    32'(issued),    32'(FD));
    check("stall_pix_valid", 32'(pix_valid), 32'd1);
    check("stall_sof",       32'(sof),       32'd1);
    check("stall_head",      32'(pix_data),  32'(pix_of(BASE)));
    prdy_mode = 0;
    run_until_done(1000, -1);
    end_frame_checks("stall", FW, 1);

    // Spurious return while idle.
    flush();
    spurious_req = 1'b1;
    step();
    step();
    check("spur_err",       32'(err),       32'd1);
    check("spur_pix_valid", 32'(pix_valid), 32'd0);
    repeat (5) step();
    check("spur_err_sticky",  32'(err),       32'd1);
    check("spur_pix_valid2",  32'(pix_valid), 32'd0);
    check("spur_busy",        32'(busy),      32'd0);

    // Reset after five pixels accepted, then a clean frame.
    rdy_mode = 0; lat_lo = 3; lat_hi = 3; prdy_mode = 0;
    begin_frame();
    n = 0;
    while (accepted < 5 && n < 200) begin
      step();
      n++;
    end
    check("mid_reset_reach5", 32'(accepted >= 5), 32'd1);
    @(posedge rd_clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("mid_reset");
    rd_data_valid = 1'b0;
    start = 1'b0;
    flush();
    repeat (2) @(negedge rd_clk);
    reset = 1'b1;
    begin_frame();
    run_until_done(3000, -1);
    end_frame_checks("post_reset", FW, 1);
    check("post_reset_err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
